// File: rtl/psg_pkg.sv
// psg_pkg: register index map, default widths and reset constants for the PSG register block.
`default_nettype none

package psg_pkg;

  localparam int DEF_TONE_FREQUENCY_BITS   = 10;
  localparam int DEF_TONE_ATTENUATION_BITS = 4;
  localparam int DEF_NOISE_CONTROL_BITS    = 3;

  localparam logic [3:0] ATTEN_SILENT = 4'hF;

  // Index layout is {channel[1:0], is_attenuation}; channel 3 with bit0=0 is noise.
  localparam logic [2:0] TONE0  = 3'd0;
  localparam logic [2:0] ATTEN0 = 3'd1;
  localparam logic [2:0] TONE1  = 3'd2;
  localparam logic [2:0] ATTEN1 = 3'd3;
  localparam logic [2:0] TONE2  = 3'd4;
  localparam logic [2:0] ATTEN2 = 3'd5;
  localparam logic [2:0] NOISE  = 3'd6;
  localparam logic [2:0] ATTEN3 = 3'd7;

endpackage

`default_nettype wire

// File: rtl/write_strobe_sync.sv
// write_strobe_sync: two-flop synchronizer for the bus strobe/byte plus falling-edge write detect.
`default_nettype none

module write_strobe_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       we_n,
  output logic       write,
  output logic [7:0] data_out
);

  logic       we_s1;
  logic       we_s2;
  logic       we_prev;
  logic [7:0] data_s1;
  logic [7:0] data_s2;

  // Stages reset to idle-high so no edge is fabricated out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_s1   <= 1'b1;
      we_s2   <= 1'b1;
      we_prev <= 1'b1;
      data_s1 <= 8'h00;
      data_s2 <= 8'h00;
    end else begin
      we_s1   <= we_n;
      we_s2   <= we_s1;
      we_prev <= we_s2;
      data_s1 <= data_in;
      data_s2 <= data_s1;
    end
  end

  assign write    = we_prev & ~we_s2;
  assign data_out = data_s2;

endmodule

`default_nettype wire

// File: rtl/psg_register_control.sv
// psg_register_control: latch/data byte protocol decoding into tone, attenuation and noise registers.
`default_nettype none

module psg_register_control
  import psg_pkg::*;
#(
  parameter int TONE_FREQUENCY_BITS   = DEF_TONE_FREQUENCY_BITS,
  parameter int TONE_ATTENUATION_BITS = DEF_TONE_ATTENUATION_BITS,
  parameter int NOISE_CONTROL_BITS    = DEF_NOISE_CONTROL_BITS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       data_in,
  input  logic                             we_n,
  output logic [TONE_FREQUENCY_BITS-1:0]   tone_period_0,
  output logic [TONE_FREQUENCY_BITS-1:0]   tone_period_1,
  output logic [TONE_FREQUENCY_BITS-1:0]   tone_period_2,
  output logic [TONE_ATTENUATION_BITS-1:0] attenuation_0,
  output logic [TONE_ATTENUATION_BITS-1:0] attenuation_1,
  output logic [TONE_ATTENUATION_BITS-1:0] attenuation_2,
  output logic [TONE_ATTENUATION_BITS-1:0] attenuation_3,
  output logic [NOISE_CONTROL_BITS-1:0]    noise_control,
  output logic                             noise_restart,
  output logic [2:0]                       latched_reg
);

  logic       write;
  logic [7:0] wbyte;
  logic       is_latch;
  logic [2:0] target;

  logic [TONE_FREQUENCY_BITS-1:0]   tone_q  [3];
  logic [TONE_ATTENUATION_BITS-1:0] atten_q [4];

  write_strobe_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .we_n     (we_n),
    .write    (write),
    .data_out (wbyte)
  );

  // A latch byte names its own target; a data byte reuses the last latched one.
  always_comb begin
    is_latch = wbyte[7];
    target   = is_latch ? wbyte[6:4] : latched_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) tone_q[i] <= '0;
      for (int i = 0; i < 4; i++) atten_q[i] <= {TONE_ATTENUATION_BITS{1'b1}};
      noise_control <= '0;
      noise_restart <= 1'b0;
      latched_reg   <= 3'd0;
    end else begin
      noise_restart <= 1'b0;
      if (write) begin
        if (is_latch) latched_reg <= wbyte[6:4];
        if (target == NOISE) begin
          noise_control <= wbyte[NOISE_CONTROL_BITS-1:0];
          noise_restart <= 1'b1;
        end else if (target[0]) begin
          atten_q[target[2:1]] <= wbyte[TONE_ATTENUATION_BITS-1:0];
        end else if (is_latch) begin
          tone_q[target[2:1]][3:0] <= wbyte[3:0];
        end else begin
          tone_q[target[2:1]][TONE_FREQUENCY_BITS-1:4] <= wbyte[TONE_FREQUENCY_BITS-5:0];
        end
      end
    end
  end

  assign tone_period_0 = tone_q[0];
  assign tone_period_1 = tone_q[1];
  assign tone_period_2 = tone_q[2];
  assign attenuation_0 = atten_q[0];
  assign attenuation_1 = atten_q[1];
  assign attenuation_2 = atten_q[2];
  assign attenuation_3 = atten_q[3];

endmodule

`default_nettype wire

// File: tb/tb_psg_register_control.sv
// tb_psg_register_control: randomized bus writes against a register-map model, scoreboarded per cycle.
`default_nettype none

module tb_psg_register_control;

  typedef struct packed {
    logic [9:0] t0, t1, t2;
    logic [3:0] a0, a1, a2, a3;
    logic [2:0] nc, lr;
  } st_t;

  typedef struct {
    int   cyc;
    st_t  st;
    logic pulse;
  } ent_t;

  typedef struct {
    string       name;
    logic [15:0] act;
    logic [15:0] exp;
  } probe_t;

  localparam st_t RESET_ST = '{t0: 10'd0, t1: 10'd0, t2: 10'd0,
                               a0: 4'hF, a1: 4'hF, a2: 4'hF, a3: 4'hF,
                               nc: 3'd0, lr: 3'd0};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       we_n;
  logic [9:0] tone_period_0, tone_period_1, tone_period_2;
  logic [3:0] attenuation_0, attenuation_1, attenuation_2, attenuation_3;
  logic [2:0] noise_control;
  logic       noise_restart;
  logic [2:0] latched_reg;

  psg_register_control dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .we_n          (we_n),
    .tone_period_0 (tone_period_0),
    .tone_period_1 (tone_period_1),
    .tone_period_2 (tone_period_2),
    .attenuation_0 (attenuation_0),
    .attenuation_1 (attenuation_1),
    .attenuation_2 (attenuation_2),
    .attenuation_3 (attenuation_3),
    .noise_control (noise_control),
    .noise_restart (noise_restart),
    .latched_reg   (latched_reg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ent_t   q[$];
  probe_t probes[$];
  st_t    model = RESET_ST;
  st_t    cur   = RESET_ST;
  int     checks = 0;
  int     errors = 0;
  int     nr_seen = 0;

  function automatic logic [9:0] tone_upd(logic [9:0] old, logic [7:0] b);
    int o = int'(old);
    int v = int'(b);
    if (v >= 128) return 10'((o / 16) * 16 + v % 16);
    return 10'((v % 64) * 16 + o % 16);
  endfunction

  function automatic st_t apply(st_t s, logic [7:0] b);
    if (b[7]) s.lr = b[6:4];
    case (s.lr)
      3'd0: s.t0 = tone_upd(s.t0, b);
      3'd1: s.a0 = b[3:0];
      3'd2: s.t1 = tone_upd(s.t1, b);
      3'd3: s.a1 = b[3:0];
      3'd4: s.t2 = tone_upd(s.t2, b);
      3'd5: s.a2 = b[3:0];
      3'd6: s.nc = b[2:0];
      default: s.a3 = b[3:0];
    endcase
    return s;
  endfunction

  // Called at a negedge; the next posedge is the first edge that samples we_n low.
  task automatic do_write(input logic [7:0] b, input int low, input int gap);
    ent_t e;
    logic [2:0] tgt;
    tgt      = b[7] ? b[6:4] : model.lr;
    data_in  = b;
    we_n     = 1'b0;
    model    = apply(model, b);
    e.cyc    = cyc + 3;
    e.st     = model;
    e.pulse  = (tgt == 3'd6);
    q.push_back(e);
    repeat (low) @(negedge clk);
    we_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic probe(input string name, input logic [15:0] act, input logic [15:0] exp);
    probe_t p;
    p.name = name;
    p.act  = act;
    p.exp  = exp;
    probes.push_back(p);
  endtask

  always @(negedge clk) begin
    st_t    act;
    logic   pexp;
    probe_t p;
    if (cyc >= 1) begin
      pexp = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        cur  = q[0].st;
        pexp = q[0].pulse;
        void'(q.pop_front());
      end
      act = '{t0: tone_period_0, t1: tone_period_1, t2: tone_period_2,
              a0: attenuation_0, a1: attenuation_1, a2: attenuation_2, a3: attenuation_3,
              nc: noise_control, lr: latched_reg};
      checks++;
      if (act !== cur) begin
        errors++;
        $display("FAIL state cyc=%0d actual=%h required=%h", cyc, act, cur);
      end
      checks++;
      if (noise_restart !== pexp) begin
        errors++;
        $display("FAIL noise_restart cyc=%0d actual=%b required=%b", cyc, noise_restart, pexp);
      end
      if (noise_restart === 1'b1) nr_seen++;
    end
    while (probes.size() > 0) begin
      p = probes.pop_front();
      checks++;
      if (p.act !== p.exp) begin
        errors++;
        $display("FAIL %s actual=%h required=%h", p.name, p.act, p.exp);
      end
    end
  end

  initial begin
    int pulses0;
    int n;
    reset   = 1'b1;
    we_n    = 1'b1;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    do_write(8'h8E, 1, 3);
    do_write(8'h0F, 2, 3);
    probe("tone0_0FE", 16'(tone_period_0), 16'h00FE);

    do_write(8'hD5, 1, 3);
    probe("atten2_latch", 16'(attenuation_2), 16'h0005);
    probe("latched_reg", 16'(latched_reg), 16'h0005);
    do_write(8'h03, 1, 3);
    probe("atten2_data", 16'(attenuation_2), 16'h0003);

    pulses0 = nr_seen;
    do_write(8'hE4, 1, 2);
    do_write(8'h07, 1, 3);
    probe("noise_ctrl", 16'(noise_control), 16'h0007);
    probe("noise_pulses", 16'(nr_seen - pulses0), 16'h0002);

    do_write(8'hA1, 20, 4);
    probe("tone1_lo", 16'(tone_period_1[3:0]), 16'h0001);

    repeat (80) begin
      n = $urandom_range(0, 3);
      // Bias toward noise and latch bytes so every register sees traffic.
      if (n == 0) do_write(8'hE0 | 8'($urandom_range(0, 7)), $urandom_range(1, 4), $urandom_range(2, 4));
      else        do_write(8'($urandom), $urandom_range(1, 4), $urandom_range(2, 4));
    end

    // Reset lands in the detection cycle of a 0x9A write.
    data_in = 8'h9A;
    we_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    we_n  = 1'b1;
    model = RESET_ST;
    begin
      ent_t e;
      e.cyc   = cyc + 1;
      e.st    = RESET_ST;
      e.pulse = 1'b0;
      q.push_back(e);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    probe("atten0_after_reset", 16'(attenuation_0), 16'h000F);

    repeat (4) @(negedge clk);
    probe("queue_drained", 16'(q.size()), 16'h0000);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
